// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch front end: fetchbuffer request/response,
// queue entry layout and the fetch sequencer register/state.
package fetch_wires;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } fetch_queue_entry_type;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FENCE = 1'b1
  } fetch_state_type;

  typedef struct packed {
    logic [31:0]     pc;
    fetch_state_type state;
  } fetch_reg_type;

  // Standard RVC encoding: only 2'b11 in the low bits marks a 32-bit instruction.
  function automatic logic is_compressed(input logic [1:0] low_bits);
    return low_bits != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Request/response bundle between the fetch sequencer (master) and the fetchbuffer (slave).
// A request transfers in a cycle where mem_valid and mem_ready are both 1; while
// mem_valid is 1 without mem_ready, the master keeps mem_addr stable.
interface fetch_stage_if import fetch_wires::*;;
  mem_in_type  fetchbuffer_in;
  mem_out_type fetchbuffer_out;

  modport master (output fetchbuffer_in, input fetchbuffer_out);
  modport slave  (input fetchbuffer_in, output fetchbuffer_out);
endinterface

// File: rtl/fetch_queue.sv
// Small circular buffer of fetched instructions; head is read straight from flops.
module fetch_queue import fetch_wires::*; #(
  parameter  int depth = 2,
  localparam int aw    = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  fetch_queue_entry_type push_data,
  input  logic                  pop,
  output fetch_queue_entry_type head,
  output logic [aw:0]           count
);

  localparam logic [aw-1:0] ptr_one    = 1;
  localparam logic [aw:0]   cnt_one    = 1;
  localparam logic [aw:0]   full_count = (aw+1)'(depth);

  fetch_queue_entry_type mem [depth];
  logic [aw-1:0] wptr;
  logic [aw-1:0] rptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + ptr_one;
      end
      if (pop) rptr <= rptr + ptr_one;
      if (push && !pop)      count <= count + cnt_one;
      else if (pop && !push) count <= count - cnt_one;
    end
  end

  assign head = mem[rptr];

  // The sequencer only requests while there is room (or a pop frees a slot).
  push_not_full: assert property (@(posedge clk) disable iff (!rst)
    (push && !flush && !pop) |-> (count != full_count));

endmodule

// File: rtl/fetch_stage.sv
// Front-end PC sequencer: issues fetchbuffer requests, steps the PC by 2/4,
// queues fetched instructions for decode and handles redirects and fence.i.
module fetch_stage import fetch_wires::*; #(
  parameter logic [31:0] reset_pc    = 32'h80000000,
  parameter int          queue_depth = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               fence_i,
  fetch_stage_if.master      fb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic               out_comp,
  output fetch_state_type    dbg_state
);

  localparam int            qaw        = $clog2(queue_depth);
  localparam logic [qaw:0]  full_count = (qaw+1)'(queue_depth);

  fetch_reg_type         r, rin, v;
  fetch_queue_entry_type push_data, head;
  logic [qaw:0]          count;
  logic                  pop, push, flush, can_req, accept, comp;
  logic [31:0]           rdata;

  assign rdata   = fb.fetchbuffer_out.mem_rdata;
  assign out_valid = (count != '0);
  assign pop     = out_valid & out_ready;
  assign can_req = (count < full_count) | pop;
  assign accept  = rst & (r.state == RUN) & can_req & fb.fetchbuffer_out.mem_ready;
  assign flush   = fence_i | redirect_valid;
  assign push    = accept & ~flush;
  assign comp    = is_compressed(rdata[1:0]);

  assign push_data.pc    = r.pc;
  assign push_data.instr = comp ? {16'h0000, rdata[15:0]} : rdata;
  assign push_data.comp  = comp;

  fetch_queue #(.depth(queue_depth)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r.pc    <= reset_pc;
      r.state <= RUN;
    end else begin
      r <= rin;
    end
  end

  // fence_i outranks redirect_valid; FENCE always lasts a single cycle.
  always_comb begin
    v = r;
    if (fence_i) begin
      v.pc    = redirect_pc & ~32'h1;
      v.state = FENCE;
    end else if (redirect_valid) begin
      v.pc    = redirect_pc & ~32'h1;
      v.state = RUN;
    end else begin
      if (push) v.pc = r.pc + (comp ? 32'd2 : 32'd4);
      v.state = RUN;
    end
    rin = v;
  end

  always_comb begin
    fb.fetchbuffer_in           = '0;
    fb.fetchbuffer_in.mem_addr  = r.pc;
    fb.fetchbuffer_in.mem_instr = 1'b1;
    if (rst) begin
      if (r.state == FENCE) begin
        fb.fetchbuffer_in.mem_valid = 1'b1;
        fb.fetchbuffer_in.mem_fence = 1'b1;
      end else begin
        fb.fetchbuffer_in.mem_valid = can_req;
      end
    end
  end

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_comp  = head.comp;
  assign dbg_state = r.state;

endmodule
